inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 133 +++++++++++++
 tb/tb_inst_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Dual-issue instruction queue between fetch and decode.
//               Circular buffer of DEPTH {instruction, PC} entries. Fetch may
//               push up to two entries per cycle, and only when ready_o is
//               high. Decode consumes up to two entries per cycle. The two
//               oldest entries are always presented on the outputs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           in   clock, rising edge
//   rst_ni          in   asynchronous active-low reset
//   flush_i         in   discard all entries (redirect / mispredict)
//   push_en_i[1:0]  in   bit0 pushes slot 0, bit1 pushes slot 1 (with bit0)
//   inst0_i/inst1_i in   fetched instructions for slots 0 / 1
//   pc0_i/pc1_i     in   PCs of those instructions
//   ready_o         out  at least two free entries
//   inst0_o/inst1_o out  oldest / second-oldest instruction (0 when invalid)
//   pc0_o/pc1_o     out  PCs of those entries (0 when invalid)
//   was_fetched0_o  out  slot 0 output valid
//   was_fetched1_o  out  slot 1 output valid
//   pop_i[1:0]      in   entries consumed this cycle (3 treated as 2)
//   count_o         out  current occupancy
// ============================================================================
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [1:0]                 push_en_i,
  input  logic [31:0]                inst0_i,
  input  logic [31:0]                inst1_i,
  input  logic [31:0]                pc0_i,
  input  logic [31:0]                pc1_i,
  output logic                       ready_o,
  output logic [31:0]                inst0_o,
  output logic [31:0]                inst1_o,
  output logic [31:0]                pc0_o,
  output logic [31:0]                pc1_o,
  output logic                       was_fetched0_o,
  output logic                       was_fetched1_o,
  input  logic [1:0]                 pop_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // Entry storage is deliberately not reset; invalid slots are masked to zero.
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_req;
  logic [1:0]    w_pop_eff;
  logic [AW-1:0] w_head_p1;
  logic [AW-1:0] w_tail_p1;

  // ready depends on registered occupancy only, so fetch never sees a
  // combinational path from decode's pop.
  assign ready_o   = (C_DEPTH - r_count) >= CW'(2);

  assign w_head_p1 = r_head + AW'(1);
  assign w_tail_p1 = r_tail + AW'(1);

  // 2'b10 (slot 1 without slot 0) is not a legal push and is dropped.
  always_comb begin
    w_push_n = 2'd0;
    if (ready_o && !flush_i) begin
      case (push_en_i)
        2'b01:   w_push_n = 2'd1;
        2'b11:   w_push_n = 2'd2;
        default: w_push_n = 2'd0;
      endcase
    end
  end

  // Pop request saturates at 2, then is clamped to the current occupancy.
  // When the request exceeds count, count is 0 or 1, so its low bits suffice.
  always_comb begin
    w_pop_req = (pop_i == 2'b11) ? 2'd2 : pop_i;
    w_pop_eff = w_pop_req;
    if (CW'(w_pop_req) > r_count) begin
      w_pop_eff = r_count[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop_eff);
      r_tail  <= r_tail + AW'(w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_n != 2'd0) begin
      r_inst[r_tail] <= inst0_i;
      r_pc[r_tail]   <= pc0_i;
    end
    if (w_push_n == 2'd2) begin
      r_inst[w_tail_p1] <= inst1_i;
      r_pc[w_tail_p1]   <= pc1_i;
    end
  end

  assign was_fetched0_o = (r_count >= CW'(1));
  assign was_fetched1_o = (r_count >= CW'(2));

  assign inst0_o = was_fetched0_o ? r_inst[r_head]    : 32'h0;
  assign pc0_o   = was_fetched0_o ? r_pc[r_head]      : 32'h0;
  assign inst1_o = was_fetched1_o ? r_inst[w_head_p1] : 32'h0;
  assign pc1_o   = was_fetched1_o ? r_pc[w_head_p1]   : 32'h0;

  assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_queue
// Description : Self-checking bench for inst_queue (DEPTH = 8). Directed
//               vector table plus hand sequences for flush, async reset and
//               a wrapping random-pop stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [1:0]  push_en_i;
  logic [31:0] inst0_i, inst1_i, pc0_i, pc1_i;
  logic        ready_o;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        was_fetched0_o, was_fetched1_o;
  logic [1:0]  pop_i;
  logic [3:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  inst_queue #(.DEPTH(8)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .push_en_i      (push_en_i),
    .inst0_i        (inst0_i),
    .inst1_i        (inst1_i),
    .pc0_i          (pc0_i),
    .pc1_i          (pc1_i),
    .ready_o        (ready_o),
    .inst0_o        (inst0_o),
    .inst1_o        (inst1_o),
    .pc0_o          (pc0_o),
    .pc1_o          (pc1_o),
    .was_fetched0_o (was_fetched0_o),
    .was_fetched1_o (was_fetched1_o),
    .pop_i          (pop_i),
    .count_o        (count_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the rising edge, sample 1 ns later.
  task automatic step(input logic fl, input logic [1:0] pe,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] pp);
    flush_i = fl; push_en_i = pe;
    inst0_i = i0; inst1_i = i1; pc0_i = p0; pc1_i = p1;
    pop_i = pp;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; push_en_i = 2'b00; pop_i = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  pe;
    logic [31:0] p0, p1;
    logic [1:0]  pop;
    logic [3:0]  cnt;
    logic        rdy, wf0, wf1;
    logic [31:0] xp0, xp1;
  } vec_t;

  vec_t vt [18];

  initial begin
    int next_in, next_out, size, eff, cyc;
    logic [1:0] pp, pe;
    logic mrdy;

    // {push_en, pc0, pc1, pop} -> {count, ready, wf0, wf1, pc0_o, pc1_o}
    vt[0]  = '{2'b01, 32'hA0,  32'h0,   2'd0, 4'd1, 1, 1, 0, 32'hA0,  32'h0};
    vt[1]  = '{2'b11, 32'hA4,  32'hA8,  2'd1, 4'd2, 1, 1, 1, 32'hA4,  32'hA8};
    vt[2]  = '{2'b10, 32'hEE0, 32'hEE4, 2'd0, 4'd2, 1, 1, 1, 32'hA4,  32'hA8};
    vt[3]  = '{2'b00, 32'h0,   32'h0,   2'd3, 4'd0, 1, 0, 0, 32'h0,   32'h0};
    vt[4]  = '{2'b01, 32'hAC,  32'h0,   2'd2, 4'd1, 1, 1, 0, 32'hAC,  32'h0};
    vt[5]  = '{2'b00, 32'h0,   32'h0,   2'd2, 4'd0, 1, 0, 0, 32'h0,   32'h0};
    vt[6]  = '{2'b11, 32'h200, 32'h204, 2'd0, 4'd2, 1, 1, 1, 32'h200, 32'h204};
    vt[7]  = '{2'b11, 32'h208, 32'h20C, 2'd0, 4'd4, 1, 1, 1, 32'h200, 32'h204};
    vt[8]  = '{2'b11, 32'h210, 32'h214, 2'd0, 4'd6, 1, 1, 1, 32'h200, 32'h204};
    vt[9]  = '{2'b11, 32'h218, 32'h21C, 2'd0, 4'd8, 0, 1, 1, 32'h200, 32'h204};
    vt[10] = '{2'b11, 32'h220, 32'h224, 2'd0, 4'd8, 0, 1, 1, 32'h200, 32'h204};
    vt[11] = '{2'b01, 32'h228, 32'h0,   2'd1, 4'd7, 0, 1, 1, 32'h204, 32'h208};
    vt[12] = '{2'b11, 32'h22C, 32'h230, 2'd0, 4'd7, 0, 1, 1, 32'h204, 32'h208};
    vt[13] = '{2'b11, 32'h230, 32'h234, 2'd2, 4'd5, 1, 1, 1, 32'h20C, 32'h210};
    vt[14] = '{2'b00, 32'h0,   32'h0,   2'd1, 4'd4, 1, 1, 1, 32'h210, 32'h214};
    vt[15] = '{2'b11, 32'h240, 32'h244, 2'd2, 4'd4, 1, 1, 1, 32'h218, 32'h21C};
    vt[16] = '{2'b00, 32'h0,   32'h0,   2'd2, 4'd2, 1, 1, 1, 32'h240, 32'h244};
    vt[17] = '{2'b00, 32'h0,   32'h0,   2'd1, 4'd1, 1, 1, 0, 32'h244, 32'h0};

    rst_ni = 1'b0; flush_i = 1'b0; push_en_i = 2'b00; pop_i = 2'b00;
    inst0_i = '0; inst1_i = '0; pc0_i = '0; pc1_i = '0;
    #12;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_wf0",   32'(was_fetched0_o), 32'd0);
    check("rst_wf1",   32'(was_fetched1_o), 32'd0);
    check("rst_inst0", inst0_o, 32'h0);
    check("rst_pc1",   pc1_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // First push after reset, both slots.
    step(0, 2'b11, 32'h00000013, 32'h00500093, 32'h100, 32'h104, 2'd0);
    check("first_count", 32'(count_o), 32'd2);
    check("first_wf0",   32'(was_fetched0_o), 32'd1);
    check("first_wf1",   32'(was_fetched1_o), 32'd1);
    check("first_inst0", inst0_o, 32'h00000013);
    check("first_inst1", inst1_o, 32'h00500093);
    check("first_pc0",   pc0_o, 32'h100);
    check("first_pc1",   pc1_o, 32'h104);
    step(0, 2'b00, 0, 0, 0, 0, 2'd2);
    check("drain_count", 32'(count_o), 32'd0);

    for (int i = 0; i < 18; i++) begin
      step(0, vt[i].pe, inst_of(vt[i].p0), inst_of(vt[i].p1), vt[i].p0, vt[i].p1, vt[i].pop);
      check($sformatf("v%0d_count", i), 32'(count_o), 32'(vt[i].cnt));
      check($sformatf("v%0d_ready", i), 32'(ready_o), 32'(vt[i].rdy));
      check($sformatf("v%0d_wf0", i),   32'(was_fetched0_o), 32'(vt[i].wf0));
      check($sformatf("v%0d_wf1", i),   32'(was_fetched1_o), 32'(vt[i].wf1));
      check($sformatf("v%0d_pc0", i),   pc0_o, vt[i].xp0);
      check($sformatf("v%0d_pc1", i),   pc1_o, vt[i].xp1);
      check($sformatf("v%0d_inst0", i), inst0_o, vt[i].wf0 ? inst_of(vt[i].xp0) : 32'h0);
      check($sformatf("v%0d_inst1", i), inst1_o, vt[i].wf1 ? inst_of(vt[i].xp1) : 32'h0);
    end

    // Grow to 5 entries, then flush together with a push.
    step(0, 2'b11, inst_of(32'h250), inst_of(32'h254), 32'h250, 32'h254, 2'd0);
    step(0, 2'b11, inst_of(32'h258), inst_of(32'h25C), 32'h258, 32'h25C, 2'd0);
    check("pre_flush_count", 32'(count_o), 32'd5);
    step(1, 2'b11, inst_of(32'h260), inst_of(32'h264), 32'h260, 32'h264, 2'd0);
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_wf0",   32'(was_fetched0_o), 32'd0);
    check("flush_pc0",   pc0_o, 32'h0);
    step(0, 2'b01, inst_of(32'h270), 0, 32'h270, 0, 2'd0);
    check("post_flush_pc0", pc0_o, 32'h270);

    // Asynchronous reset mid-stream, taken while the clock is high.
    step(0, 2'b11, inst_of(32'h300), inst_of(32'h304), 32'h300, 32'h304, 2'd0);
    check("pre_rst_count", 32'(count_o), 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_wf0",   32'(was_fetched0_o), 32'd0);
    check("arst_inst0", inst0_o, 32'h0);
    check("arst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 2'b11, inst_of(32'h400), inst_of(32'h404), 32'h400, 32'h404, 2'd0);
    check("after_rst_count", 32'(count_o), 32'd2);
    check("after_rst_pc0",   pc0_o, 32'h400);
    check("after_rst_pc1",   pc1_o, 32'h404);
    step(0, 2'b00, 0, 0, 0, 0, 2'd2);

    // Stream 40 sequential PCs with random pops; outputs must leave in order.
    next_in = 0; next_out = 0; size = 0; cyc = 0;
    while (next_out < 40 && cyc < 400) begin
      pe   = (next_in < 40) ? 2'b11 : 2'b00;
      pp   = 2'($urandom_range(0, 2));
      mrdy = (8 - size) >= 2;
      eff  = (int'(pp) < size) ? int'(pp) : size;
      check("str_count", 32'(count_o), 32'(size));
      check("str_ready", 32'(ready_o), 32'(mrdy));
      if (eff >= 1) begin
        check("str_pc0",   pc0_o, 32'h1000 + 32'(4 * next_out));
        check("str_inst0", inst0_o, inst_of(32'h1000 + 32'(4 * next_out)));
      end
      if (eff == 2) check("str_pc1", pc1_o, 32'h1000 + 32'(4 * (next_out + 1)));
      step(0, pe, inst_of(32'h1000 + 32'(4 * next_in)), inst_of(32'h1004 + 32'(4 * next_in)),
           32'h1000 + 32'(4 * next_in), 32'h1004 + 32'(4 * next_in), pp);
      if (mrdy && pe == 2'b11) begin
        size += 2;
        next_in += 2;
      end
      size -= eff;
      next_out += eff;
      cyc++;
    end
    check("stream_done", 32'(next_out), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
